// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, register map and divider helper for the UART peripheral
package uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic REG_CTRL = 1'b0;
    localparam logic REG_DATA = 1'b1;

    localparam int CTRL_SEND_BIT   = 0;
    localparam int CTRL_NEW_RX_BIT = 1;
    localparam int CTRL_OVR_BIT    = 2;

    function automatic int tick_div(input int clk, input int baud, input int os);
        return clk / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider emitting a one-cycle oversample tick
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/uart_perif_regs.sv
// rtl/uart_perif_regs.sv - register-mapped 8N1 UART TX/RX; overrun flag built only with UART_OVERRUN_EN
module uart_perif_regs
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_i,
    input  logic        reg_sel_i,
    input  logic [31:0] entrada_i,
    output logic [31:0] salida_o,
    input  logic        rx_i,
    output logic        tx_o
);
    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);

    logic           tick;
    logic           send, new_rx, ovr;
    logic [7:0]     tx_data, tx_shift, rx_data, rx_shift;
    tx_state_t      tx_state;
    rx_state_t      rx_state;
    logic [OSW-1:0] tx_ticks, rx_ticks;
    logic [2:0]     tx_bits, rx_bits;
    logic           rx_meta, rx_sync;
    logic           wr_ctrl, tx_done, rx_good;
    logic           unused_bits;

    uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk_i),
        .reset (reset_i),
        .tick  (tick)
    );

    assign wr_ctrl     = wr_i && (reg_sel_i == REG_CTRL);
    assign tx_done     = (tx_state == TX_STOP) && tick && (tx_ticks == OS_LAST);
    assign rx_good     = (rx_state == RX_STOP) && tick && (rx_ticks == OS_LAST) && rx_sync;
    assign unused_bits = ^entrada_i[31:8];
    assign salida_o    = (reg_sel_i == REG_DATA) ? {24'b0, rx_data} : {29'b0, ovr, new_rx, send};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state <= TX_IDLE;
            tx_o     <= 1'b1;
            tx_shift <= '0;
            tx_ticks <= '0;
            tx_bits  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_o <= 1'b1;
                    if (send) begin
                        tx_shift <= tx_data;
                        tx_bits  <= '0;
                        tx_ticks <= '0;
                        tx_o     <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: if (tick) begin
                    if (tx_ticks == OS_LAST) begin
                        tx_ticks <= '0;
                        tx_o     <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else tx_ticks <= tx_ticks + OSW'(1);
                end
                TX_DATA: if (tick) begin
                    if (tx_ticks == OS_LAST) begin
                        tx_ticks <= '0;
                        if (tx_bits == 3'd7) begin
                            tx_o     <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bits  <= tx_bits + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_o     <= tx_shift[1];
                        end
                    end else tx_ticks <= tx_ticks + OSW'(1);
                end
                TX_STOP: if (tick) begin
                    if (tx_ticks == OS_LAST) tx_state <= TX_IDLE;
                    else tx_ticks <= tx_ticks + OSW'(1);
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // START waits half a bit so every later sample lands mid-bit
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_ticks <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            case (rx_state)
                RX_IDLE: if (!rx_sync) begin
                    rx_ticks <= '0;
                    rx_state <= RX_START;
                end
                RX_START: if (tick) begin
                    if (rx_ticks == OS_HALF) begin
                        rx_ticks <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else rx_ticks <= rx_ticks + OSW'(1);
                end
                RX_DATA: if (tick) begin
                    if (rx_ticks == OS_LAST) begin
                        rx_ticks <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bits == 3'd7) rx_state <= RX_STOP;
                        else rx_bits <= rx_bits + 3'd1;
                    end else rx_ticks <= rx_ticks + OSW'(1);
                end
                RX_STOP: if (tick) begin
                    if (rx_ticks == OS_LAST) begin
                        rx_state <= RX_IDLE;
                        if (rx_sync) rx_data <= rx_shift;
                    end else rx_ticks <= rx_ticks + OSW'(1);
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Hardware events take priority over software clears of the same flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            send    <= 1'b0;
            new_rx  <= 1'b0;
            tx_data <= '0;
        end else begin
            if (wr_i && (reg_sel_i == REG_DATA)) tx_data <= entrada_i[7:0];
            if (wr_ctrl && entrada_i[CTRL_SEND_BIT]) send <= 1'b1;
            else if (tx_done) send <= 1'b0;
            if (wr_ctrl) new_rx <= entrada_i[CTRL_NEW_RX_BIT];
            if (rx_good) new_rx <= 1'b1;
        end
    end

`ifdef UART_OVERRUN_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ovr <= 1'b0;
        end else begin
            if (wr_ctrl) ovr <= entrada_i[CTRL_OVR_BIT];
            if (rx_good && new_rx) ovr <= 1'b1;
        end
    end
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_perif_regs.sv
// tb/tb_uart_perif_regs.sv - directed self-checking bench for uart_perif_regs at 160 clk per bit
module tb_uart_perif_regs;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr = 1'b0;
    logic        reg_sel = 1'b0;
    logic [31:0] entrada = '0;
    logic [31:0] salida;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx, tx;
    int          checks = 0;
    int          errors = 0;

`ifdef UART_OVERRUN_EN
    localparam logic [31:0] CTRL_OVR_EXP = 32'h6;
`else
    localparam logic [31:0] CTRL_OVR_EXP = 32'h2;
`endif

    always #5 clk = ~clk;
    assign rx = loop_en ? tx : rx_drv;

    uart_perif_regs #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_i      (wr),
        .reg_sel_i (reg_sel),
        .entrada_i (entrada),
        .salida_o  (salida),
        .rx_i      (rx),
        .tx_o      (tx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic sel, input logic [31:0] v);
        wr = 1'b1; reg_sel = sel; entrada = v;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic read_reg(input logic sel, output logic [31:0] v);
        reg_sel = sel;
        #1;
        v = salida;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
        rx_drv = 1'b0;
        repeat (160) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (160) @(negedge clk);
        end
        rx_drv = stop;
        repeat (stop_len) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic wait_tx_low(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (tx == 1'b0) ok = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] v;
        logic        ok;
        logic [7:0]  b;
        logic [7:0]  lb [2];
        int          skew;
        logic        exp_bit;

        lb[0] = 8'h00; lb[1] = 8'hFF;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_tx", tx, 1);
        read_reg(0, v); check("reset_ctrl", v, 0);
        read_reg(1, v); check("reset_data", v, 0);

        // TX frame 0xA5, with a CTRL=0 write mid-frame
        b = 8'hA5;
        write_reg(1, 32'hA5);
        write_reg(0, 32'h1);
        wait_tx_low(ok);
        check("tx_start_seen", ok, 1);
        skew = 0;
        for (int k = 0; k < 10; k++) begin
            repeat ((k == 0 ? 80 : 160) - skew) @(negedge clk);
            skew = 0;
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            check($sformatf("tx_bit%0d", k), tx, exp_bit);
            if (k == 0) begin
                read_reg(0, v); check("ctrl_busy", v, 1);
            end
            if (k == 4) begin
                write_reg(0, 32'h0);
                read_reg(0, v); check("ctrl_no_abort", v, 1);
                skew = 1;
            end
        end
        repeat (100) @(negedge clk);
        read_reg(0, v); check("ctrl_after_tx", v, 0);
        check("tx_idle_after", tx, 1);

        // Good RX frame
        send_frame(8'h3C, 1'b1, 160);
        repeat (5) @(negedge clk);
        read_reg(0, v); check("rx_ctrl", v, 2);
        read_reg(1, v); check("rx_data", v, 32'h3C);
        write_reg(0, 32'h0);
        read_reg(0, v); check("rx_clear", v, 0);

        // Glitch and framing error
        rx_drv = 1'b0;
        repeat (40) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        read_reg(0, v); check("glitch_ctrl", v, 0);
        send_frame(8'hA7, 1'b0, 120);
        repeat (250) @(negedge clk);
        read_reg(0, v); check("frame_err_ctrl", v, 0);
        read_reg(1, v); check("frame_err_data", v, 32'h3C);

        // Overwrite and overrun
        send_frame(8'hA1, 1'b1, 160);
        repeat (5) @(negedge clk);
        read_reg(0, v); check("first_ctrl", v, 2);
        send_frame(8'h55, 1'b1, 160);
        repeat (5) @(negedge clk);
        read_reg(0, v); check("overrun_ctrl", v, CTRL_OVR_EXP);
        read_reg(1, v); check("overwrite_data", v, 32'h55);
        write_reg(0, 32'h0);
        read_reg(0, v); check("overrun_clear", v, 0);

        // Software clear in the exact completion cycle loses to the hardware set
        ok = 1'b0;
        fork
            send_frame(8'hC3, 1'b1, 160);
            begin
                for (int i = 0; i < 3000 && !ok; i++) begin
                    @(negedge clk);
                    if (dut.rx_good) begin
                        ok = 1'b1;
                        wr = 1'b1; reg_sel = 1'b0; entrada = 32'h0;
                        @(negedge clk);
                        wr = 1'b0;
                    end
                end
            end
        join
        check("completion_seen", ok, 1);
        read_reg(0, v); check("completion_ctrl", v, 2);
        read_reg(1, v); check("completion_data", v, 32'hC3);
        write_reg(0, 32'h0);

        // Reset mid data bit
        write_reg(1, 32'h5A);
        write_reg(0, 32'h1);
        wait_tx_low(ok);
        check("tx2_start_seen", ok, 1);
        repeat (240) @(negedge clk);
        check("tx2_bit0", tx, 0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_tx", tx, 1);
        reset = 1'b0;
        read_reg(0, v); check("reset_mid_ctrl", v, 0);
        repeat (400) @(negedge clk);
        check("no_resume_tx", tx, 1);

        // Loopback
        loop_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            write_reg(1, {24'b0, lb[k]});
            write_reg(0, 32'h1);
            ok = 1'b0;
            for (int i = 0; i < 3000 && !ok; i++) begin
                @(negedge clk);
                read_reg(0, v);
                if (v[0] == 1'b0) ok = 1'b1;
            end
            check($sformatf("lb%0d_done", k), ok, 1);
            repeat (20) @(negedge clk);
            read_reg(1, v); check($sformatf("lb%0d_data", k), v, {24'b0, lb[k]});
            read_reg(0, v); check($sformatf("lb%0d_ctrl", k), v, 2);
            write_reg(0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
